uart_param_baud: RTL and testbench

Parametrised successor to the fixed-format 8N1 UART used for host control of the DDS core. The frame format is set per instance: data width 5–8, parity none/odd/even, one or two stop bits. RX uses a 2-FF synchroniser and mid-bit sampling, validates parity and stop bits, and buffers received words in an N-deep FIFO with sticky error and overflow flags. It sits between the board UART pins and the command parser, so the parser can drain bytes in bursts instead of polling per byte.

---
 rtl/uart_param_baud.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_uart_param_baud.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_param_baud.sv
// Parametrised UART: configurable data width, parity and stop bits on both directions.
// RX words land in a power-of-two FIFO with sticky parity, framing and overflow flags.
module uart_param_baud #(
  parameter int unsigned clock_freq = 100_000_000,
  parameter int unsigned baud_rate  = 115200,
  parameter int unsigned data_bits  = 8,
  parameter int unsigned parity     = 0,
  parameter int unsigned stop_bits  = 1,
  parameter int unsigned fifo_depth = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic                        tx,
  input  logic [data_bits-1:0]        tx_data,
  input  logic                        tx_start,
  output logic                        tx_idle,
  output logic                        tx_done,
  output logic [data_bits-1:0]        rx_data,
  output logic                        rx_valid,
  input  logic                        rx_rd,
  output logic [$clog2(fifo_depth):0] rx_count,
  output logic                        rx_perr,
  output logic                        rx_ferr,
  output logic                        rx_ovf,
  input  logic                        rx_clr
);

  localparam int unsigned Div    = (clock_freq + baud_rate / 2) / baud_rate;
  localparam int unsigned Hdiv   = Div / 2;
  localparam int unsigned CntW   = $clog2(Div + 1);
  localparam int unsigned AddrW  = $clog2(fifo_depth);
  localparam int unsigned CountW = AddrW + 1;

  localparam logic [CntW-1:0]   CntLast   = CntW'(Div - 1);
  localparam logic [CntW-1:0]   CntHalf   = CntW'(Hdiv - 1);
  localparam logic [2:0]        BitLast   = 3'(data_bits - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(fifo_depth);
  localparam bit                HasParity = (parity != 0);
  localparam bit                OddParity = (parity == 1);
  localparam bit                TwoStop   = (stop_bits == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------------------------------------------------------- transmitter
  state_e                tx_state_q, tx_state_d;
  logic [CntW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [2:0]            tx_bit_q, tx_bit_d;
  logic [data_bits-1:0]  tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_stop_q, tx_stop_d;
  logic                  tx_line_q, tx_line_d;
  logic                  tx_done_q, tx_done_d;
  logic                  tx_tick;

  assign tx_tick = (tx_cnt_q == CntLast);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    tx_line_d  = tx_line_q;
    tx_done_d  = 1'b0;
    case (tx_state_q)
      StIdle: begin
        if (tx_start) begin
          tx_state_d = StStart;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_stop_d  = 1'b0;
          tx_shift_d = tx_data;
          tx_par_d   = OddParity ? ~^tx_data : ^tx_data;
          tx_line_d  = 1'b0;
        end
      end
      StStart: begin
        if (tx_tick) begin
          tx_cnt_d   = '0;
          tx_state_d = StData;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (tx_tick) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BitLast) begin
            tx_state_d = HasParity ? StParity : StStop;
            tx_line_d  = HasParity ? tx_par_q : 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = tx_shift_q >> 1;
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      StParity: begin
        if (tx_tick) begin
          tx_cnt_d   = '0;
          tx_state_d = StStop;
          tx_line_d  = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (tx_tick) begin
          tx_cnt_d = '0;
          if (TwoStop && !tx_stop_q) begin
            tx_stop_d = 1'b1;
          end else begin
            tx_state_d = StIdle;
            tx_done_d  = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CntW'(1);
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_stop_q  <= tx_stop_d;
      tx_line_q  <= tx_line_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx      = tx_line_q;
  assign tx_idle = (tx_state_q == StIdle);
  assign tx_done = tx_done_q;

  // ------------------------------------------------------------------- receiver
  logic [1:0]            sync_q;
  logic                  rx_s;
  logic                  rx_prev_q;
  state_e                rx_state_q, rx_state_d;
  logic [CntW-1:0]       rx_cnt_q, rx_cnt_d;
  logic [2:0]            rx_bit_q, rx_bit_d;
  logic [data_bits-1:0]  rx_shift_q, rx_shift_d;
  logic                  rx_pbad_q, rx_pbad_d;
  logic                  rx_tick;
  logic                  push, perr_set, ferr_set;

  assign rx_s    = sync_q[1];
  assign rx_tick = (rx_cnt_q == CntLast);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_pbad_d  = rx_pbad_q;
    push       = 1'b0;
    perr_set   = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state_q)
      StIdle: begin
        // Edge, not level: after a framing error the line must go high before re-arming.
        if (rx_prev_q && !rx_s) begin
          rx_state_d = StStart;
          rx_cnt_d   = '0;
        end
      end
      StStart: begin
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_pbad_d  = 1'b0;
          rx_state_d = rx_s ? StIdle : StData;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[data_bits-1:1]};
          if (rx_bit_q == BitLast) begin
            rx_state_d = HasParity ? StParity : StStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      StParity: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_pbad_d  = rx_s ^ (OddParity ? ~^rx_shift_q : ^rx_shift_q);
          rx_state_d = StStop;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          push       = 1'b1;
          perr_set   = rx_pbad_q;
          ferr_set   = !rx_s;
          rx_state_d = StIdle;
        end else begin
          rx_cnt_d = rx_cnt_q + CntW'(1);
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_pbad_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_pbad_q  <= rx_pbad_d;
    end
  end

  // ----------------------------------------------------------------------- FIFO
  logic [data_bits-1:0] mem_q [fifo_depth];
  logic [AddrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0]    count_q;
  logic                 pop_ok, push_ok;

  assign pop_ok  = rx_rd && (count_q != '0);
  // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
  assign push_ok = push && ((count_q != CountFull) || pop_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(fifo_depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= rx_shift_q;
        wr_ptr_q        <= wr_ptr_q + AddrW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (push_ok && !pop_ok) count_q <= count_q + CountW'(1);
      else if (!push_ok && pop_ok) count_q <= count_q - CountW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_perr <= 1'b0;
      rx_ferr <= 1'b0;
      rx_ovf  <= 1'b0;
    end else if (rx_clr) begin
      rx_perr <= 1'b0;
      rx_ferr <= 1'b0;
      rx_ovf  <= 1'b0;
    end else begin
      if (perr_set) rx_perr <= 1'b1;
      if (ferr_set) rx_ferr <= 1'b1;
      if (push && !push_ok) rx_ovf <= 1'b1;
    end
  end

  assign rx_data  = mem_q[rd_ptr_q];
  assign rx_valid = (count_q != '0);
  assign rx_count = count_q;

endmodule

// File: tb/tb_uart_param_baud.sv
// Bench for uart_param_baud: an 8N1 instance in loopback and a 7E2 instance driven by the bench,
// both at div=10 with 4-deep FIFOs; received words are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_uart_param_baud;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #500 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 8N1 instance, tx looped back to rx
  logic       a_tx, a_tx_idle, a_tx_done, a_rx_valid, a_perr, a_ferr, a_ovf;
  logic [7:0] a_tx_data = 8'h00;
  logic       a_tx_start = 1'b0, a_rx_rd = 1'b0, a_clr = 1'b0;
  logic [7:0] a_rx_data;
  logic [2:0] a_rx_count;

  // 7E2 instance, rx driven by the bench
  logic       b_line = 1'b1;
  logic       b_tx, b_tx_idle, b_tx_done, b_rx_valid, b_perr, b_ferr, b_ovf;
  logic [6:0] b_tx_data = 7'h00;
  logic       b_tx_start = 1'b0, b_rx_rd = 1'b0, b_clr = 1'b0;
  logic [6:0] b_rx_data;
  logic [2:0] b_rx_count;

  uart_param_baud #(
    .clock_freq(1_000_000), .baud_rate(100_000), .data_bits(8), .parity(0),
    .stop_bits(1), .fifo_depth(4)
  ) dut_a (
    .clk(clk), .rst(rst), .rx(a_tx), .tx(a_tx), .tx_data(a_tx_data), .tx_start(a_tx_start),
    .tx_idle(a_tx_idle), .tx_done(a_tx_done), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
    .rx_rd(a_rx_rd), .rx_count(a_rx_count), .rx_perr(a_perr), .rx_ferr(a_ferr),
    .rx_ovf(a_ovf), .rx_clr(a_clr)
  );

  uart_param_baud #(
    .clock_freq(1_000_000), .baud_rate(100_000), .data_bits(7), .parity(2),
    .stop_bits(2), .fifo_depth(4)
  ) dut_b (
    .clk(clk), .rst(rst), .rx(b_line), .tx(b_tx), .tx_data(b_tx_data), .tx_start(b_tx_start),
    .tx_idle(b_tx_idle), .tx_done(b_tx_done), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
    .rx_rd(b_rx_rd), .rx_count(b_rx_count), .rx_perr(b_perr), .rx_ferr(b_ferr),
    .rx_ovf(b_ovf), .rx_clr(b_clr)
  );

  logic [7:0] sb_a[$];
  logic [6:0] sb_b[$];
  logic       exp_ovf_a = 1'b0;

  typedef struct {
    logic [6:0] data;
    bit         flip;
    bit         stop0;
    int         hold;
    bit         exp_perr;
    bit         exp_ferr;
  } rx_vec_t;
  rx_vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts an 8N1 frame at the current negedge and returns at the tx_done cycle.
  task automatic send_a(input logic [7:0] d, input bit wave, input bit lat, input bit simul);
    logic [9:0] fr;
    logic [7:0] head;
    fr   = {1'b1, d, 1'b0};
    head = 8'h00;
    if (simul) head = sb_a.pop_front();
    if (sb_a.size() < 4) sb_a.push_back(d);
    else exp_ovf_a = 1'b1;
    a_tx_data  = d;
    a_tx_start = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      if (k == 1) a_tx_start = 1'b0;
      if (k <= 100) begin
        if (wave) check("a_tx_bit", a_tx, fr[(k-1)/10]);
        if (wave && k == 100) check("a_tx_done_early", a_tx_done, 0);
      end else begin
        check("a_tx_done", a_tx_done, 1);
        check("a_tx_idle", a_tx_idle, 1);
      end
      if (lat && k == 98) check("a_rx_valid_early", a_rx_valid, 0);
      if (lat && k == 99) check("a_rx_valid_latency", a_rx_valid, 1);
      if (simul && k == 98) begin
        check("a_head_before_simul", a_rx_data, head);
        a_rx_rd = 1'b1;
      end
      if (simul && k == 99) begin
        a_rx_rd = 1'b0;
        check("a_simul_count", a_rx_count, 4);
        check("a_simul_ovf", a_ovf, 0);
        check("a_simul_head", a_rx_data, sb_a[0]);
      end
    end
  endtask

  task automatic pop_a();
    logic [7:0] exp;
    check("a_pop_valid", a_rx_valid, 1);
    if (sb_a.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL a_pop_scoreboard: got data expected none");
    end else begin
      exp = sb_a.pop_front();
      check("a_pop_data", a_rx_data, exp);
    end
    a_rx_rd = 1'b1;
    @(negedge clk);
    a_rx_rd = 1'b0;
  endtask

  task automatic pop_b();
    logic [6:0] exp;
    check("b_pop_valid", b_rx_valid, 1);
    if (sb_b.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL b_pop_scoreboard: got data expected none");
    end else begin
      exp = sb_b.pop_front();
      check("b_pop_data", b_rx_data, exp);
    end
    b_rx_rd = 1'b1;
    @(negedge clk);
    b_rx_rd = 1'b0;
  endtask

  task automatic send_b(input logic [6:0] d);
    logic [10:0] fr;
    fr         = {2'b11, ^d, d, 1'b0};
    b_tx_data  = d;
    b_tx_start = 1'b1;
    for (int k = 1; k <= 111; k++) begin
      @(negedge clk);
      if (k == 1) b_tx_start = 1'b0;
      if (k <= 110) begin
        check("b_tx_bit", b_tx, fr[(k-1)/10]);
        if (k == 110) check("b_tx_done_early", b_tx_done, 0);
      end else begin
        check("b_tx_done", b_tx_done, 1);
        check("b_tx_idle", b_tx_idle, 1);
      end
    end
  endtask

  // Drives a 7E2 frame into dut_b; optionally corrupts parity or holds a low stop bit.
  task automatic b_drive(input logic [6:0] d, input bit flip, input bit stop0, input int hold);
    logic [9:0] fr;
    fr = {~stop0, (^d) ^ flip, d, 1'b0};
    sb_b.push_back(d);
    for (int i = 0; i < 10; i++) begin
      b_line = fr[i];
      tick(10);
    end
    if (stop0) tick(hold);
    b_line = 1'b1;
    tick(40);
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vecs[0] = '{data: 7'h41, flip: 1'b1, stop0: 1'b0, hold: 0,   exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[1] = '{data: 7'h41, flip: 1'b0, stop0: 1'b0, hold: 0,   exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[2] = '{data: 7'h2A, flip: 1'b0, stop0: 1'b1, hold: 150, exp_perr: 1'b0, exp_ferr: 1'b1};
    vecs[3] = '{data: 7'h7F, flip: 1'b0, stop0: 1'b0, hold: 0,   exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[4] = '{data: 7'h00, flip: 1'b1, stop0: 1'b0, hold: 0,   exp_perr: 1'b1, exp_ferr: 1'b0};

    tick(3);
    check("rst_a_tx", a_tx, 1);
    check("rst_a_tx_idle", a_tx_idle, 1);
    check("rst_a_tx_done", a_tx_done, 0);
    check("rst_a_rx_valid", a_rx_valid, 0);
    check("rst_a_rx_count", a_rx_count, 0);
    check("rst_a_rx_data", a_rx_data, 0);
    check("rst_a_flags", {a_perr, a_ferr, a_ovf}, 0);
    check("rst_b_tx", b_tx, 1);
    check("rst_b_flags", {b_perr, b_ferr, b_ovf}, 0);
    rst = 1'b1;
    tick(3);

    // Basic 8N1 frame and loopback
    send_a(8'hA5, 1'b1, 1'b1, 1'b0);
    check("a_basic_flags", {a_perr, a_ferr, a_ovf}, 0);
    pop_a();
    check("a_basic_empty", a_rx_valid, 0);

    // Overflow: five back-to-back frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_a(8'(i), 1'b0, 1'b0, 1'b0);
    check("a_ovf_count", a_rx_count, sb_a.size());
    check("a_ovf_flag", a_ovf, exp_ovf_a);
    for (int i = 0; i < 4; i++) pop_a();
    check("a_drained", a_rx_valid, 0);
    a_rx_rd = 1'b1;
    tick(1);
    a_rx_rd = 1'b0;
    check("a_rd_empty_count", a_rx_count, 0);
    a_clr = 1'b1;
    tick(1);
    a_clr = 1'b0;
    exp_ovf_a = 1'b0;
    check("a_ovf_cleared", a_ovf, exp_ovf_a);

    // Simultaneous push and pop at full
    for (int i = 0; i < 4; i++) send_a(8'h11 + 8'(i), 1'b0, 1'b0, 1'b0);
    check("a_full_count", a_rx_count, 4);
    send_a(8'h15, 1'b0, 1'b0, 1'b1);
    check("a_simul_ovf_after", a_ovf, exp_ovf_a);
    for (int i = 0; i < 4; i++) pop_a();
    check("a_simul_drained", a_rx_valid, 0);

    // 7E2 transmit
    send_b(7'h41);

    // 7E2 receive vectors
    foreach (vecs[i]) begin
      b_clr = 1'b1;
      tick(1);
      b_clr = 1'b0;
      check("b_clr_perr", b_perr, 0);
      check("b_clr_ferr", b_ferr, 0);
      b_drive(vecs[i].data, vecs[i].flip, vecs[i].stop0, vecs[i].hold);
      check("b_vec_perr", b_perr, vecs[i].exp_perr);
      check("b_vec_ferr", b_ferr, vecs[i].exp_ferr);
      check("b_vec_count", b_rx_count, 1);
      pop_b();
      check("b_vec_empty", b_rx_valid, 0);
    end
    b_clr = 1'b1;
    tick(1);
    b_clr = 1'b0;
    check("b_perr_cleared", b_perr, 0);

    // Short low glitch on idle rx
    b_line = 1'b0;
    tick(3);
    b_line = 1'b1;
    tick(150);
    check("b_glitch_count", b_rx_count, 0);
    check("b_glitch_flags", {b_perr, b_ferr, b_ovf}, 0);

    // Reset in the middle of data bit 3
    send_a(8'h3C, 1'b0, 1'b0, 1'b0);
    check("a_pre_reset_count", a_rx_count, 1);
    a_tx_data  = 8'h96;
    a_tx_start = 1'b1;
    tick(1);
    a_tx_start = 1'b0;
    tick(44);
    rst = 1'b0;
    #1;
    check("mid_rst_tx", a_tx, 1);
    check("mid_rst_tx_idle", a_tx_idle, 1);
    check("mid_rst_count", a_rx_count, 0);
    check("mid_rst_valid", a_rx_valid, 0);
    sb_a.delete();
    tick(2);
    rst = 1'b1;
    tick(5);
    send_a(8'h5A, 1'b1, 1'b1, 1'b0);
    pop_a();
    check("a_final_empty", a_rx_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
